image_load_ctrl: RTL and testbench
==================================

# image_load_ctrl

Frame-level sequencer for the digit-recognition datapath. Accepts the 98-byte image stream from the UART receiver, unpacks each byte LSB-first into the 1024×1 input-image RAM, starts the SNN core once the 784-bit frame is complete, and sends the core's 4-bit result back through the UART transmitter. It also arbitrates the single RAM port between the UART loader (write) and the SNN core (read).

## Interface
Parameters:
- NUM_BYTES, 98, bytes per frame (784 pixels / 8)
- TIMEOUT_CYCLES, 2000000, maximum idle gap between bytes inside a frame (40 ms at 50 MHz); used only with LOAD_TIMEOUT_EN

Ports:
- clk  in  1  system clock, 50 MHz, rising edge
- rst  in  1  asynchronous, active-high reset
- rx_rdy  in  1  one-cycle pulse: rx_data holds a valid byte
- rx_data  in  8  received byte; bit 0 is the lowest pixel address
- core_addr  in  10  SNN core read address
- core_done  in  1  one-cycle pulse: core_digit is valid
- core_digit  in  4  classified digit, 0–9
- tx_rdy  in  1  UART transmitter idle
- ram_addr  out  10  RAM address, muxed between loader and core
- ram_we  out  1  RAM write enable
- ram_wdata  out  1  RAM write bit
- core_start  out  1  one-cycle start pulse to the core
- tx_start  out  1  one-cycle start pulse to the UART transmitter
- tx_data  out  8  {4'h0, result}
- result  out  4  last classified digit, held until the next core_done
- busy  out  1  high in every state except IDLE
- ovr  out  1  sticky flag: a byte arrived while it could not be accepted
- frame_err  out  1  sticky flag: a frame was aborted on timeout (tied 0 without LOAD_TIMEOUT_EN)

## Operation
- States: IDLE, WAIT_BYTE, UNPACK, RUN, TX, TX_WAIT.
- IDLE:
  - On rx_rdy: capture rx_data into shift register sr, set byte_idx=0 and bit_idx=0, clear ovr and frame_err, go to UNPACK.
- UNPACK (8 cycles):
  - Drive ram_we=1, ram_addr={byte_idx[6:0], bit_idx[2:0]}, ram_wdata=sr[0]; shift sr right; increment bit_idx.
  - When bit_idx==7, this is the last write of the byte.
    - If byte_idx==NUM_BYTES-1, go to RUN and pulse core_start for one cycle.
    - Otherwise increment byte_idx and go to WAIT_BYTE.
- WAIT_BYTE: on rx_rdy, capture the byte, clear bit_idx, go to UNPACK.
- RUN:
  - ram_addr=core_addr, ram_we=0.
  - On core_done: latch result<=core_digit and go to TX.
- TX: assert tx_start for exactly one cycle (the first TX cycle), then wait in TX until tx_rdy==0.
- TX_WAIT: when tx_rdy==1, go to IDLE.
- Port arbitration:
  - Only UNPACK may write; only RUN forwards core_addr.
  - In all other states, ram_addr=0 and ram_we=0. The core can never see a partially written frame.
- Overrun:
  - rx_rdy in UNPACK, RUN, TX or TX_WAIT: the byte is dropped, ovr is set, and the state is unaffected.
- Arithmetic:
  - byte_idx is 7 bits and bit_idx is 3 bits.
  - The maximum address is 783; addresses 784–1023 are never written.
- Reset (any time, including mid-frame or mid-transmit):
  - State goes to IDLE.
  - Counters, sr, result, ovr, frame_err, and every output go to 0.
  - A partial frame is discarded; the next rx_rdy starts a new frame at address 0.

## Timing
- rx_rdy at cycle N: writes occur at cycles N+1 through N+8 for addresses byte*8+0 through byte*8+7.
- Last write of byte 97 at cycle M: core_start at M+1, and the state is RUN from M+1.
- core_done at cycle K: result is valid and tx_start=1 at K+1.
- ram_addr is registered from state and counters; core_addr passes combinationally only in RUN.
- Minimum frame load time is 98×9 cycles; UART byte spacing (≈4340 cycles at 115200 baud) never causes an overrun in normal use.

## Configuration
- LOAD_TIMEOUT_EN defined:
  - A 21-bit gap counter clears on each accepted byte and counts in WAIT_BYTE.
  - When it reaches TIMEOUT_CYCLES-1: set frame_err, go to IDLE, clear byte_idx.
- LOAD_TIMEOUT_EN undefined: no gap counter, frame_err is tied 0, and WAIT_BYTE waits indefinitely.

## Test plan
- Full frame: send 98 bytes of 0xA5 → RAM bits alternate 1,0,1,0,0,1,0,1 per byte; exactly one core_start, one cycle after the write to address 783.
- Result path: core_done with core_digit=7 → result=7 and tx_start high for exactly one cycle the next cycle, with tx_data=8'h07; return to IDLE only after tx_rdy falls then rises.
- Arbitration: during RUN, drive core_addr=10'h155 → ram_addr=10'h155 and ram_we=0; in IDLE, ram_addr=0 and ram_we=0.
- Overrun: rx_rdy during RUN → ovr=1, state stays RUN; the next frame's first byte clears ovr.
- Reset mid-frame: rst after 40 bytes, then a fresh 98 bytes → writes start at address 0 and core_start fires only after byte 98 of the new frame.
- With LOAD_TIMEOUT_EN and TIMEOUT_CYCLES=100: stop after 10 bytes → frame_err=1 and IDLE after 100 gap cycles; the next byte writes address 0.

Source files
------------

// File: rtl/image_load_ctrl.sv
// Frame sequencer: unpacks UART bytes into the 1024x1 image RAM, starts the SNN core and returns its digit.
// Optional inter-byte load timeout is compiled in with LOAD_TIMEOUT_EN.
module image_load_ctrl #(
    parameter int NUM_BYTES      = 98,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    input  logic [9:0] core_addr,
    input  logic       core_done,
    input  logic [3:0] core_digit,
    input  logic       tx_rdy,
    output logic [9:0] ram_addr,
    output logic       ram_we,
    output logic       ram_wdata,
    output logic       core_start,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic [3:0] result,
    output logic       busy,
    output logic       ovr,
    output logic       frame_err
);

    // state     | meaning
    // IDLE      | no frame in progress, waiting for the first byte
    // WAIT_BYTE | frame partially loaded, waiting for the next byte
    // UNPACK    | writing the captured byte to RAM, one bit per cycle
    // RUN       | core owns the RAM port, waiting for core_done
    // TX        | tx_start pulse, then wait for the transmitter to go busy
    // TX_WAIT   | wait for the transmitter to return idle
    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        UNPACK,
        RUN,
        TX,
        TX_WAIT
    } state_t;

    localparam logic [6:0] LAST_BYTE = 7'(NUM_BYTES - 1);

    state_t     state_q, state_d;
    logic [7:0] sr_q, sr_d;
    logic [6:0] byte_idx_q, byte_idx_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [3:0] result_q, result_d;
    logic       ovr_q, ovr_d;
    logic [9:0] ram_addr_q, ram_addr_d;
    logic       ram_we_q, ram_we_d;
    logic       ram_wdata_q, ram_wdata_d;
    logic       core_start_q, core_start_d;
    logic       tx_start_q, tx_start_d;
    logic       busy_q, busy_d;

`ifdef LOAD_TIMEOUT_EN
    localparam logic [20:0] GAP_LOAD = 21'(TIMEOUT_CYCLES - 1);
    logic [20:0] gap_q, gap_d;
    logic        frame_err_q, frame_err_d;
`else
    localparam bit unused_timeout_cycles = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        byte_idx_d   = byte_idx_q;
        bit_idx_d    = bit_idx_q;
        result_d     = result_q;
        ovr_d        = ovr_q;
        core_start_d = 1'b0;
        tx_start_d   = 1'b0;
`ifdef LOAD_TIMEOUT_EN
        gap_d        = gap_q;
        frame_err_d  = frame_err_q;
`endif

        case (state_q)
            IDLE: begin
                if (rx_rdy) begin
                    sr_d       = rx_data;
                    byte_idx_d = '0;
                    bit_idx_d  = '0;
                    ovr_d      = 1'b0;
                    state_d    = UNPACK;
`ifdef LOAD_TIMEOUT_EN
                    frame_err_d = 1'b0;
                    gap_d       = GAP_LOAD;
`endif
                end
            end
            WAIT_BYTE: begin
                if (rx_rdy) begin
                    sr_d      = rx_data;
                    bit_idx_d = '0;
                    state_d   = UNPACK;
`ifdef LOAD_TIMEOUT_EN
                    gap_d     = GAP_LOAD;
`endif
                end
`ifdef LOAD_TIMEOUT_EN
                else if (gap_q == '0) begin
                    frame_err_d = 1'b1;
                    byte_idx_d  = '0;
                    state_d     = IDLE;
                end else begin
                    gap_d = gap_q - 21'd1;
                end
`endif
            end
            UNPACK: begin
                sr_d      = {1'b0, sr_q[7:1]};
                bit_idx_d = bit_idx_q + 3'd1;
                if (bit_idx_q == 3'd7) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d      = RUN;
                        core_start_d = 1'b1;
                    end else begin
                        byte_idx_d = byte_idx_q + 7'd1;
                        state_d    = WAIT_BYTE;
                    end
                end
            end
            RUN: begin
                if (core_done) begin
                    result_d   = core_digit;
                    tx_start_d = 1'b1;
                    state_d    = TX;
                end
            end
            // Ignore tx_rdy during the pulse cycle so a still-idle flag cannot be misread
            TX: begin
                if (!tx_start_q && !tx_rdy) begin
                    state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (tx_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rx_rdy && (state_q == UNPACK || state_q == RUN ||
                       state_q == TX || state_q == TX_WAIT)) begin
            ovr_d = 1'b1;
        end

        // Port outputs are computed from the next state so they register in step with it
        ram_we_d    = (state_d == UNPACK);
        ram_addr_d  = ram_we_d ? {byte_idx_d, bit_idx_d} : 10'd0;
        ram_wdata_d = ram_we_d & sr_d[0];
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            sr_q         <= '0;
            byte_idx_q   <= '0;
            bit_idx_q    <= '0;
            result_q     <= '0;
            ovr_q        <= 1'b0;
            ram_addr_q   <= '0;
            ram_we_q     <= 1'b0;
            ram_wdata_q  <= 1'b0;
            core_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
`ifdef LOAD_TIMEOUT_EN
            gap_q        <= '0;
            frame_err_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            byte_idx_q   <= byte_idx_d;
            bit_idx_q    <= bit_idx_d;
            result_q     <= result_d;
            ovr_q        <= ovr_d;
            ram_addr_q   <= ram_addr_d;
            ram_we_q     <= ram_we_d;
            ram_wdata_q  <= ram_wdata_d;
            core_start_q <= core_start_d;
            tx_start_q   <= tx_start_d;
            busy_q       <= busy_d;
`ifdef LOAD_TIMEOUT_EN
            gap_q        <= gap_d;
            frame_err_q  <= frame_err_d;
`endif
        end
    end

    assign ram_addr   = (state_q == RUN) ? core_addr : ram_addr_q;
    assign ram_we     = ram_we_q;
    assign ram_wdata  = ram_wdata_q;
    assign core_start = core_start_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = {4'h0, result_q};
    assign result     = result_q;
    assign busy       = busy_q;
    assign ovr        = ovr_q;
`ifdef LOAD_TIMEOUT_EN
    assign frame_err  = frame_err_q;
`else
    assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_image_load_ctrl.sv
// Self-checking bench for image_load_ctrl: table-driven frames, random frames, reset and gap corner cases.
module tb_image_load_ctrl;
    localparam int NB = 98;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_rdy;
    logic [7:0] rx_data;
    logic [9:0] core_addr;
    logic       core_done;
    logic [3:0] core_digit;
    logic       tx_rdy;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic       ram_wdata;
    logic       core_start;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [3:0] result;
    logic       busy;
    logic       ovr;
    logic       frame_err;

    image_load_ctrl #(.NUM_BYTES(NB), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .core_addr(core_addr), .core_done(core_done), .core_digit(core_digit),
        .tx_rdy(tx_rdy), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .core_start(core_start), .tx_start(tx_start), .tx_data(tx_data),
        .result(result), .busy(busy), .ovr(ovr), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_wr = 0, n_start = 0, n_tx = 0, n_oob = 0;
    int start_cyc = -1, last_wr_cyc = -1;
    logic ram_model [1024];
    logic [7:0] frame_bytes [NB];

    typedef struct {
        logic [7:0] fill;
        bit         rnd;
        logic [3:0] digit;
        int         where;   // 0 none, 1 rx in RUN, 2 rx in UNPACK, 3 rx in TX_WAIT
        logic [9:0] probe;
        logic [7:0] exp_tx;
        bit         exp_ovr;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // RAM / pulse monitor, sampled just after each rising edge
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst) begin
            if (ram_we) begin
                n_wr++;
                if (ram_addr >= 10'd784) n_oob++;
                else ram_model[ram_addr] = ram_wdata;
                if (ram_addr == 10'd783) last_wr_cyc = cyc;
            end
            if (core_start) begin
                n_start++;
                start_cyc = cyc;
            end
            if (tx_start) n_tx++;
        end
    end

    task automatic do_reset();
        step();
        rst = 1'b1;
        rx_rdy = 1'b0; core_done = 1'b0; core_addr = '0; tx_rdy = 1'b1;
        #1;
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_wdata", ram_wdata, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_result", result, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ovr, 0);
        chk("rst_frame_err", frame_err, 0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int idx, input bit inj);
        logic [9:0] base;
        base = 10'(idx * 8);
        step();
        rx_rdy = 1'b1;
        rx_data = b;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) begin
                rx_rdy = 1'b0;
                rx_data = 8'($urandom);
            end
            chk("wr_en", ram_we, 1);
            chk("wr_addr", ram_addr, base + 10'(i));
            chk("wr_bit", ram_wdata, b[i]);
            if (idx == 0 && i == 0) begin
                chk("ovr_clear", ovr, 0);
                chk("ferr_clear", frame_err, 0);
            end
            if (inj && i == 2) begin
                rx_rdy = 1'b1;
                rx_data = ~b;
            end
            if (inj && i == 3) rx_rdy = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [3:0] digit, input int where, input logic [9:0] probe,
                             input logic [7:0] exp_tx, input bit exp_ovr);
        int mism;
        int gap;
        int hold;
        for (int a = 0; a < 1024; a++) ram_model[a] = 1'bx;
        n_wr = 0; n_start = 0; n_tx = 0; n_oob = 0; start_cyc = -1; last_wr_cyc = -1;

        for (int b = 0; b < NB; b++) begin
            if (b != 0) begin
                gap = $urandom_range(0, 3);
                for (int g = 0; g < gap; g++) begin
                    step();
                    chk("wait_we", ram_we, 0);
                    chk("wait_busy", busy, 1);
                end
            end
            send_byte(frame_bytes[b], b, (where == 2) && (b == 50));
            if (where == 2 && b == 50) chk("ovr_unpack", ovr, 1);
        end

        step();
        chk("core_start", core_start, 1);
        chk("run_we", ram_we, 0);
        chk("run_busy", busy, 1);
        core_addr = probe;
        step();
        chk("start_once", core_start, 0);
        chk("run_addr", ram_addr, probe);
        chk("run_we2", ram_we, 0);
        chk("start_count", n_start, 1);
        chk("start_latency", start_cyc - last_wr_cyc, 1);

        mism = 0;
        for (int a = 0; a < 784; a++)
            if (ram_model[a] !== frame_bytes[a / 8][a % 8]) mism++;
        chk("ram_image", mism, 0);
        chk("wr_count", n_wr, 784);
        chk("wr_above_783", n_oob, 0);

        repeat ($urandom_range(0, 4)) begin
            step();
            chk("run_hold_busy", busy, 1);
            chk("run_hold_addr", ram_addr, probe);
        end
        if (where == 1) begin
            rx_rdy = 1'b1;
            rx_data = 8'($urandom);
            step();
            rx_rdy = 1'b0;
            step();
            chk("ovr_run", ovr, 1);
            chk("ovr_still_run", ram_addr, probe);
            chk("ovr_busy", busy, 1);
        end

        core_done = 1'b1;
        core_digit = digit;
        step();
        core_done = 1'b0;
        core_digit = 4'($urandom);
        chk("tx_start", tx_start, 1);
        chk("result", result, digit);
        chk("tx_data", tx_data, exp_tx);
        chk("tx_ram_addr", ram_addr, 0);
        chk("tx_ram_we", ram_we, 0);
        step();
        chk("tx_start_once", tx_start, 0);

        hold = $urandom_range(0, 3);
        for (int h = 0; h < hold; h++) begin
            step();
            chk("tx_busy", busy, 1);
        end
        tx_rdy = 1'b0;
        step();
        if (where == 3) begin
            rx_rdy = 1'b1;
            rx_data = 8'($urandom);
            step();
            rx_rdy = 1'b0;
            chk("ovr_txwait", ovr, 1);
        end
        step();
        step();
        chk("txwait_busy", busy, 1);
        tx_rdy = 1'b1;
        step();
        chk("idle_busy", busy, 0);
        chk("idle_ram_addr", ram_addr, 0);
        chk("idle_ram_we", ram_we, 0);
        chk("idle_result", result, digit);
        chk("idle_tx_data", tx_data, exp_tx);
        chk("idle_ovr", ovr, exp_ovr);
        chk("tx_count", n_tx, 1);
        chk("start_total", n_start, 1);
        chk("idle_ferr", frame_err, 0);
    endtask

    initial begin
        rx_rdy = 1'b0; rx_data = '0; core_addr = '0; core_done = 1'b0; core_digit = '0; tx_rdy = 1'b1;

        vecs[0] = '{8'hA5, 1'b0, 4'd7, 0, 10'h155, 8'h07, 1'b0};
        vecs[1] = '{8'hFF, 1'b0, 4'd9, 1, 10'h30F, 8'h09, 1'b1};
        vecs[2] = '{8'h00, 1'b0, 4'd0, 0, 10'h3FF, 8'h00, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 4'd5, 2, 10'h2AA, 8'h05, 1'b1};
        vecs[4] = '{8'h00, 1'b1, 4'd3, 3, 10'h0C4, 8'h03, 1'b1};

        do_reset();

        for (int v = 0; v < 5; v++) begin
            for (int b = 0; b < NB; b++)
                frame_bytes[b] = vecs[v].rnd ? 8'($urandom) : vecs[v].fill;
            run_frame(vecs[v].digit, vecs[v].where, vecs[v].probe, vecs[v].exp_tx, vecs[v].exp_ovr);
        end

        // Reset in the middle of byte 41, then a complete fresh frame
        for (int b = 0; b < 40; b++) send_byte(8'($urandom), b, 1'b0);
        step();
        rx_rdy = 1'b1;
        rx_data = 8'hFF;
        step();
        rx_rdy = 1'b0;
        step();
        chk("mid_frame_we", ram_we, 1);
        do_reset();
        for (int b = 0; b < NB; b++) frame_bytes[b] = 8'($urandom);
        run_frame(4'd8, 0, 10'h201, 8'h08, 1'b0);

        for (int r = 0; r < 5; r++) begin
            logic [3:0] d;
            int w;
            d = 4'($urandom_range(0, 9));
            w = $urandom_range(0, 3);
            for (int b = 0; b < NB; b++) frame_bytes[b] = 8'($urandom);
            run_frame(d, w, 10'($urandom_range(1, 1023)), {4'h0, d}, w != 0);
        end

`ifdef LOAD_TIMEOUT_EN
        for (int b = 0; b < 10; b++) send_byte(8'($urandom), b, 1'b0);
        for (int k = 1; k <= 100; k++) begin
            step();
            if (k == 100) begin
                chk("gap_busy", busy, 1);
                chk("gap_ferr", frame_err, 0);
            end
        end
        step();
        chk("timeout_idle", busy, 0);
        chk("timeout_ferr", frame_err, 1);
        send_byte(8'h96, 0, 1'b0);
        do_reset();
`else
        for (int b = 0; b < 10; b++) send_byte(8'($urandom), b, 1'b0);
        repeat (150) step();
        chk("long_gap_busy", busy, 1);
        chk("long_gap_ferr", frame_err, 0);
        chk("long_gap_we", ram_we, 0);
        send_byte(8'h96, 10, 1'b0);
        do_reset();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
